// File: rtl/vram_arb_pkg.sv
// Shared constants, CPU FSM states and pipeline tag for the CGA video RAM arbiter.
package vram_arb_pkg;
    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_LAT    = 3;

    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_LO = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FLIGHT,
        DONE
    } cpu_st_t;

    // One entry per granted slot; vid and cpu may both be set on a snow collision.
    typedef struct packed {
        logic       vid;
        logic       cpu;
        logic       lo;
        logic       snow;
        logic       wr;
        logic [7:0] wb;
    } tag_t;
endpackage

// File: rtl/vram_arb_pipe.sv
// Three-stage valid/tag pipe matching the RAM round trip; steers read data to video or CPU.
// Fixed latency, no backpressure: whatever enters leaves exactly three cycles later.
module vram_arb_pipe
    import vram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  tag_t        tag,
    input  logic [15:0] ram_rd_data,
    output logic        vid_valid,
    output logic [15:0] vid_data,
    output logic        vid_snow,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rd_data
);
    tag_t s1, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            vid_valid   <= 1'b0;
            vid_data    <= '0;
            vid_snow    <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            s1        <= tag;
            s2        <= s1;
            vid_valid <= s2.vid;
            vid_snow  <= s2.vid & s2.snow;
            cpu_ack   <= s2.cpu;
            // A snowed write never reads the RAM; video sees the replicated write word.
            if (s2.vid)
                vid_data <= (s2.snow && s2.wr) ? {s2.wb, s2.wb} : ram_rd_data;
            else
                vid_data <= '0;
            if (s2.cpu && !s2.wr)
                cpu_rd_data <= s2.lo ? ram_rd_data[7:0] : ram_rd_data[15:8];
            else
                cpu_rd_data <= '0;
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port CGA VRAM between CRTC fetches and CPU byte accesses, 3-cycle latency.
// Video wins collisions and the CPU stalls; with VRAM_ARB_SNOW_EN the CPU wins and video gets snow.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iVidReq,
    input  logic [ADDR_W-1:0]      iVidAddr,
    output logic                   oVidValid,
    output logic [15:0]            oVidData,
    output logic                   oVidSnow,
    input  logic                   iCpuReq,
    input  logic                   iCpuWr,
    input  logic [ADDR_W:0]        iCpuAddr,
    input  logic [7:0]             iCpuWrData,
    output logic                   oCpuAck,
    output logic [7:0]             oCpuRdData,
    output logic [ADDR_W-1:0]      oRamAddr,
    output logic                   oRamWe,
    output logic [1:0]             oRamBe,
    output logic [15:0]            oRamWrData,
    input  logic [15:0]            iRamRdData,
    output logic [STALL_CNT_W-1:0] oStallCnt
);
    localparam logic [1:0] LAST = 2'(VRAM_LAT - 1);

    cpu_st_t    state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       cpu_pend, cpu_gnt, vid_gnt, stall, snow_hit;
    tag_t       tag;

    // A request seen in IDLE competes for the slot immediately.
    assign cpu_pend = (state == IDLE && iCpuReq) || (state == WAIT);
    assign vid_gnt  = iVidReq;

`ifdef VRAM_ARB_SNOW_EN
    assign cpu_gnt  = cpu_pend;
    assign snow_hit = cpu_pend & iVidReq;
    assign stall    = 1'b0;
`else
    assign cpu_gnt  = cpu_pend & ~iVidReq;
    assign snow_hit = 1'b0;
    assign stall    = cpu_pend & iVidReq;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:    if (iCpuReq) state_nxt = cpu_gnt ? FLIGHT : WAIT;
            WAIT:    if (cpu_gnt) state_nxt = FLIGHT;
            FLIGHT: begin
                cnt_nxt = cnt + 2'd1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cpu_gnt) cnt_nxt = '0;
    end

    always_comb begin
        tag      = '0;
        tag.vid  = vid_gnt;
        tag.cpu  = cpu_gnt;
        tag.lo   = iCpuAddr[0];
        tag.snow = snow_hit;
        tag.wr   = cpu_gnt & iCpuWr;
        tag.wb   = iCpuWrData;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state      <= IDLE;
            cnt        <= '0;
            oStallCnt  <= '0;
            oRamAddr   <= '0;
            oRamWe     <= 1'b0;
            oRamBe     <= '0;
            oRamWrData <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            oRamWe <= cpu_gnt & iCpuWr;
            if (stall && oStallCnt != '1)
                oStallCnt <= oStallCnt + STALL_CNT_W'(1);
            if (cpu_gnt) begin
                oRamAddr   <= iCpuAddr[ADDR_W:1];
                oRamBe     <= iCpuAddr[0] ? BE_LO : BE_HI;
                oRamWrData <= {2{iCpuWrData}};
            end else if (vid_gnt) begin
                oRamAddr <= iVidAddr;
                oRamBe   <= BE_HI | BE_LO;
            end else begin
                oRamBe <= '0;
            end
        end
    end

    vram_arb_pipe u_pipe (
        .clk         (iClk),
        .rst_n       (iRstN),
        .tag         (tag),
        .ram_rd_data (iRamRdData),
        .vid_valid   (oVidValid),
        .vid_data    (oVidData),
        .vid_snow    (oVidSnow),
        .cpu_ack     (oCpuAck),
        .cpu_rd_data (oCpuRdData)
    );
endmodule
